bank_sc_xbar_rtn: RTL and testbench
===================================

Name: bank_sc_xbar_rtn

Overview:
Bank-side return unit. It sits at the bank end of the read-return path into the cross-bar ROBs. It buffers read data from the bank pipeline in per-channel FIFOs and arbitrates round-robin across channels. It drives one beat per cycle on the bank_sc_xbar interface (valid/ch_id/rob_num/data, no ready). Per-channel credits prevent overrunning the channel ROB; the ROB's spw_pop pulses return those credits.

Parameters:
FIFO_DEPTH, 4, entries per channel return FIFO (power of 2, >=2)
CH_CREDITS, 2, max beats in flight per channel (sent, not yet popped by the ROB)
CH_NUM, 3, number of channels (fixed at 3; ch_id 3 is illegal)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
rtn_push_valid_i  in  1  bank pipeline has a return beat
rtn_push_ready_o  out  1  target channel FIFO can accept the beat
rtn_push_ch_id_i  in  2  destination channel
rtn_push_rob_num_i  in  3  ROB slot tag
rtn_push_data_i  in  128  read data
sc_xbar_valid_o  out  1  return beat valid (single-cycle pulse per beat)
sc_xbar_ch_id_o  out  2  channel of beat
sc_xbar_rob_num_o  out  3  ROB slot of beat
sc_xbar_data_o  out  128  data of beat
channel_spw_pop_i  in  3  per-channel credit return from the ROB (bit = channel)

Behaviour:
- Reset (rst_i=0, async):
  - FIFOs empty, credits = CH_CREDITS, RR pointer = 0.
  - sc_xbar_valid_o=0, ch_id/rob_num/data = 0.
  - rtn_push_ready_o follows reset state: 1 for a legal ch_id.
- Push side:
  - rtn_push_ready_o = !full[rtn_push_ch_id_i] && (rtn_push_ch_id_i != 3), combinational.
  - Write occurs when valid&&ready. A beat with ch_id=3 is never accepted.
- Eligibility: eligible[c] = !empty[c] && credit[c] != 0.
- Arbitration:
  - Round-robin over eligible channels, starting at RR pointer.
  - On grant to channel g, RR pointer <= (g+1) mod 3; otherwise the pointer holds.
  - At most one grant per cycle.
- Output register:
  - On a grant, load ch_id=g, rob_num and data from FIFO g's head, set valid=1, pop FIFO g.
  - With no grant, valid=0 next cycle; ch_id/rob_num/data hold their last values.
- Latency: push accepted in cycle N into an empty FIFO, credit available, no contention -> sc_xbar_valid_o=1 in cycle N+2.
- Throughput: one beat per cycle sustained while any channel is eligible.
- Credits, per channel, counter width clog2(CH_CREDITS+1):
  - Grant only: credit-1.
  - Pop only: credit+1.
  - Grant and pop in the same cycle: unchanged.
  - Pop when credit==CH_CREDITS: saturate (no change) and flag a simulation assertion error.
- Simultaneous FIFO push and pop on the same channel: count unchanged. Full FIFO with a pop that cycle: push still refused (ready uses the registered full flag).
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer MSB.
- Ordering: per channel, beats leave in push order. There is no ordering across channels.
- Reset mid-operation: in-flight FIFO contents and credits are discarded; the ROB side is reset in the same domain.

Decomposition:
- Shared package mcash_xbar_pkg holds:
  - Constants: CH_NUM=3, ROB_NUM_W=3, DATA_W=128, CH_ID_W=2.
  - Packed struct rtn_beat_t {rob_num, data}.
- One sub-module, bank_sc_rtn_fifo: parameterised sync FIFO with full/empty, instantiated CH_NUM times.
- Arbiter and credit counters stay in the top module.

Test Plan:
- Reset then push ch1, rob 5, data 0xA5..: expect valid_o at N+2 with ch_id=1, rob_num=5, matching data; credit[1]=1.
- Push 3 beats each to ch0/ch1/ch2 in the same burst with no pops: grants go 0,1,2,0,1,2; each channel then stalls at 0 credits with 1 beat left, and valid_o stays 0.
- From the stalled state, pulse channel_spw_pop_i=3'b010: exactly one ch1 beat issues 2 cycles later; ch0/ch2 stay stalled.
- Fill ch0 FIFO to 4 entries with credits exhausted: rtn_push_ready_o=0 for ch_id=0 and 1 for ch_id=2; push with ch_id=3 gives ready=0 and no state change.
- Grant ch2 in the same cycle as spw_pop[2]: credit[2] is unchanged. Extra pop at full credit: credit stays 2 and the assertion fires.
- Assert rst_i low while the ch0 FIFO holds 2 beats and valid_o=1: valid_o drops to 0 asynchronously, FIFOs are empty and credits equal 2 after release.

Source files
------------

// File: rtl/mcash_xbar_pkg.sv
// Shared definitions for the bank-side cross-bar return path.
//   CH_NUM    : number of return channels (fixed at 3, ch_id 3 is illegal)
//   ROB_NUM_W : width of the ROB slot tag
//   DATA_W    : width of one read-data beat
//   CH_ID_W   : width of a channel id
//   rtn_beat_t: payload stored per return beat (ROB slot + data)
package mcash_xbar_pkg;

    localparam int unsigned CH_NUM    = 3;
    localparam int unsigned ROB_NUM_W = 3;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned CH_ID_W   = 2;

    typedef struct packed {
        logic [ROB_NUM_W-1:0] rob_num;
        logic [DATA_W-1:0]    data;
    } rtn_beat_t;

endpackage

// File: rtl/bank_sc_rtn_fifo.sv
// Per-channel return FIFO: synchronous, registered full/empty.
//   clk_i        in   clock
//   rst_i        in   asynchronous active-low reset (pointers only)
//   push_i       in   write push_data_i (ignored when full)
//   push_data_i  in   WIDTH-bit entry to write
//   pop_i        in   drop the head entry (ignored when empty)
//   pop_data_o   out  head entry (valid while !empty_o)
//   full_o       out  DEPTH entries held
//   empty_o      out  no entries held
module bank_sc_rtn_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 131
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry one extra MSB so that full and empty differ when the
    // index bits match.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en, pop_en;

    always_comb begin
        full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        empty_o = (wr_ptr_q == rd_ptr_q);
        push_en = push_i && !full_o;
        pop_en  = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop_en};
        pop_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is read until the pointers say so.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/bank_sc_xbar_rtn.sv
// Bank-side return unit: buffers bank read returns per channel, arbitrates
// round-robin across credited channels and drives one registered beat per
// cycle towards the cross-bar ROBs. ROB pops return channel credits.
//   clk_i               in   clock
//   rst_i               in   asynchronous active-low reset
//   rtn_push_valid_i    in   bank pipeline offers a beat
//   rtn_push_ready_o    out  target channel FIFO accepts it (ch_id 3 never)
//   rtn_push_ch_id_i    in   destination channel
//   rtn_push_rob_num_i  in   ROB slot tag
//   rtn_push_data_i     in   read data
//   sc_xbar_valid_o     out  one-cycle pulse per issued beat
//   sc_xbar_ch_id_o     out  channel of the beat (holds when idle)
//   sc_xbar_rob_num_o   out  ROB slot of the beat (holds when idle)
//   sc_xbar_data_o      out  data of the beat (holds when idle)
//   channel_spw_pop_i   in   per-channel credit return, bit = channel
module bank_sc_xbar_rtn
    import mcash_xbar_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CH_CREDITS = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rtn_push_valid_i,
    output logic         rtn_push_ready_o,
    input  logic [1:0]   rtn_push_ch_id_i,
    input  logic [2:0]   rtn_push_rob_num_i,
    input  logic [127:0] rtn_push_data_i,
    output logic         sc_xbar_valid_o,
    output logic [1:0]   sc_xbar_ch_id_o,
    output logic [2:0]   sc_xbar_rob_num_o,
    output logic [127:0] sc_xbar_data_o,
    input  logic [2:0]   channel_spw_pop_i
);

    localparam int unsigned     CR_W   = $clog2(CH_CREDITS + 1);
    localparam logic [CR_W-1:0] CR_MAX = CR_W'(CH_CREDITS);

    rtn_beat_t             push_beat;
    rtn_beat_t             head_beat [CH_NUM];
    rtn_beat_t             sel_beat;
    logic [CH_NUM-1:0]     fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CH_NUM-1:0]     eligible;
    logic [CR_W-1:0]       credit_q [CH_NUM];
    logic [CR_W-1:0]       credit_d [CH_NUM];
    logic [CH_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                  grant_valid;
    logic [CH_ID_W-1:0]    grant_ch;
    int unsigned           arb_idx;

    logic                  out_valid_q, out_valid_d;
    logic [CH_ID_W-1:0]    out_ch_q, out_ch_d;
    logic [ROB_NUM_W-1:0]  out_rob_q, out_rob_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;

    // Push side: ready comes from the registered full flag, so a full FIFO
    // popped this cycle still refuses the beat.
    always_comb begin
        push_beat.rob_num = rtn_push_rob_num_i;
        push_beat.data    = rtn_push_data_i;
        rtn_push_ready_o  = 1'b0;
        fifo_push         = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (rtn_push_ch_id_i == CH_ID_W'(c)) begin
                rtn_push_ready_o = !fifo_full[c];
                fifo_push[c]     = rtn_push_valid_i && !fifo_full[c];
            end
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_fifo
        bank_sc_rtn_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH ($bits(rtn_beat_t))
        ) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .push_i      (fifo_push[c]),
            .push_data_i (push_beat),
            .pop_i       (fifo_pop[c]),
            .pop_data_o  (head_beat[c]),
            .full_o      (fifo_full[c]),
            .empty_o     (fifo_empty[c])
        );
    end

    // Round-robin: scan channels starting at the pointer, first eligible wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        arb_idx     = 0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            eligible[c] = !fifo_empty[c] && (credit_q[c] != '0);
        end
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            arb_idx = (int'(rr_ptr_q) + i) % CH_NUM;
            if (!grant_valid && eligible[arb_idx]) begin
                grant_valid = 1'b1;
                grant_ch    = CH_ID_W'(arb_idx);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_ch == CH_ID_W'(CH_NUM - 1)) ? '0 : grant_ch + 1'b1;
        end
    end

    // Grant pops the FIFO, consumes a credit and loads the output register.
    always_comb begin
        fifo_pop = '0;
        sel_beat = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (grant_valid && grant_ch == CH_ID_W'(c)) begin
                fifo_pop[c] = 1'b1;
                sel_beat    = head_beat[c];
            end
        end
        out_valid_d = grant_valid;
        out_ch_d    = out_ch_q;
        out_rob_d   = out_rob_q;
        out_data_d  = out_data_q;
        if (grant_valid) begin
            out_ch_d   = grant_ch;
            out_rob_d  = sel_beat.rob_num;
            out_data_d = sel_beat.data;
        end
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            credit_d[c] = credit_q[c];
            unique case ({fifo_pop[c], channel_spw_pop_i[c]})
                2'b10:   credit_d[c] = credit_q[c] - 1'b1;
                2'b01:   if (credit_q[c] != CR_MAX) credit_d[c] = credit_q[c] + 1'b1;
                default: credit_d[c] = credit_q[c];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_rob_q   <= '0;
            out_data_q  <= '0;
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                credit_q[c] <= CR_MAX;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_rob_q   <= out_rob_d;
            out_data_q  <= out_data_d;
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                credit_q[c] <= credit_d[c];
            end
        end
    end

    always_comb begin
        sc_xbar_valid_o   = out_valid_q;
        sc_xbar_ch_id_o   = out_ch_q;
        sc_xbar_rob_num_o = out_rob_q;
        sc_xbar_data_o    = out_data_q;
    end

    // A pop that would push a channel above its credit limit is a ROB bug.
    for (genvar c = 0; c < CH_NUM; c++) begin : g_credit_chk
        assert property (@(posedge clk_i) disable iff (!rst_i)
            !(channel_spw_pop_i[c] && !fifo_pop[c] && credit_q[c] == CR_MAX));
    end

endmodule

// File: tb/tb_bank_sc_xbar_rtn.sv
module tb_bank_sc_xbar_rtn;

    localparam int DEPTH   = 4;
    localparam int CREDITS = 2;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         rtn_push_valid_i = 1'b0;
    logic         rtn_push_ready_o;
    logic [1:0]   rtn_push_ch_id_i = '0;
    logic [2:0]   rtn_push_rob_num_i = '0;
    logic [127:0] rtn_push_data_i = '0;
    logic         sc_xbar_valid_o;
    logic [1:0]   sc_xbar_ch_id_o;
    logic [2:0]   sc_xbar_rob_num_o;
    logic [127:0] sc_xbar_data_o;
    logic [2:0]   channel_spw_pop_i = '0;

    bank_sc_xbar_rtn #(.FIFO_DEPTH(DEPTH), .CH_CREDITS(CREDITS)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .rtn_push_valid_i   (rtn_push_valid_i),
        .rtn_push_ready_o   (rtn_push_ready_o),
        .rtn_push_ch_id_i   (rtn_push_ch_id_i),
        .rtn_push_rob_num_i (rtn_push_rob_num_i),
        .rtn_push_data_i    (rtn_push_data_i),
        .sc_xbar_valid_o    (sc_xbar_valid_o),
        .sc_xbar_ch_id_o    (sc_xbar_ch_id_o),
        .sc_xbar_rob_num_o  (sc_xbar_rob_num_o),
        .sc_xbar_data_o     (sc_xbar_data_o),
        .channel_spw_pop_i  (channel_spw_pop_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]   rob;
        logic [127:0] data;
    } mb_t;

    // Reference model: per-channel queues, credit counts, next-start channel.
    mb_t          mq [3][$];
    int           cr_m [3];
    int           rr_m;
    logic         ev;
    logic [1:0]   ech;
    logic [2:0]   erob;
    logic [127:0] edata;

    int n_checks = 0;
    int n_errors = 0;

    logic last_ready;
    int   beats_per_ch [3];
    int   grant_order [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            mq[c].delete();
            cr_m[c] = CREDITS;
        end
        rr_m  = 0;
        ev    = 1'b0;
        ech   = '0;
        erob  = '0;
        edata = '0;
    endtask

    // One clock cycle: called just after a falling edge, returns at the next.
    task automatic step(input logic pv, input logic [1:0] ch, input logic [2:0] rob,
                        input logic [127:0] d, input logic [2:0] pop);
        logic exp_ready;
        int   g;
        int   pre_cr [3];
        rtn_push_valid_i   = pv;
        rtn_push_ch_id_i   = ch;
        rtn_push_rob_num_i = rob;
        rtn_push_data_i    = d;
        channel_spw_pop_i  = pop;
        #1;
        exp_ready  = (ch != 2'd3) && (mq[ch].size() < DEPTH);
        last_ready = rtn_push_ready_o;
        chk("push_ready", {127'd0, rtn_push_ready_o}, {127'd0, exp_ready});

        for (int c = 0; c < 3; c++) pre_cr[c] = cr_m[c];
        g = -1;
        for (int i = 0; i < 3; i++) begin
            int c;
            c = (rr_m + i) % 3;
            if (g < 0 && mq[c].size() > 0 && cr_m[c] > 0) g = c;
        end
        if (g >= 0) begin
            mb_t b;
            b     = mq[g].pop_front();
            ev    = 1'b1;
            ech   = 2'(g);
            erob  = b.rob;
            edata = b.data;
            rr_m  = (g + 1) % 3;
        end else begin
            ev = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            int gc;
            gc = (g == c) ? 1 : 0;
            if (!(pop[c] && pre_cr[c] == CREDITS && gc == 0))
                cr_m[c] = pre_cr[c] - gc + (pop[c] ? 1 : 0);
        end
        if (pv && exp_ready) mq[ch].push_back('{rob: rob, data: d});

        @(posedge clk_i);
        #1;
        chk("valid", {127'd0, sc_xbar_valid_o}, {127'd0, ev});
        chk("ch_id", {126'd0, sc_xbar_ch_id_o}, {126'd0, ech});
        chk("rob_num", {125'd0, sc_xbar_rob_num_o}, {125'd0, erob});
        chk("data", sc_xbar_data_o, edata);
        if (sc_xbar_valid_o === 1'b1) begin
            beats_per_ch[sc_xbar_ch_id_o]++;
            grant_order.push_back(int'(sc_xbar_ch_id_o));
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rtn_push_valid_i  = 1'b0;
        channel_spw_pop_i = '0;
        rst_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) beats_per_ch[c] = 0;
        grant_order.delete();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] d_a5;
    logic [2:0]   rpop;
    int           guard;

    initial begin
        model_reset();
        @(negedge clk_i);
        #1;
        chk("reset_valid", {127'd0, sc_xbar_valid_o}, 128'd0);
        chk("reset_data", sc_xbar_data_o, 128'd0);
        do_reset();

        // Single beat latency: accepted at edge N, visible after edge N+1.
        d_a5 = {16{8'hA5}};
        step(1'b1, 2'd1, 3'd5, d_a5, 3'b000);
        chk("lat_ready", {127'd0, last_ready}, 128'd1);
        chk("lat_n1_valid", {127'd0, sc_xbar_valid_o}, 128'd0);
        step(1'b0, 2'd0, 3'd0, '0, 3'b000);
        chk("lat_n2_valid", {127'd0, sc_xbar_valid_o}, 128'd1);
        chk("lat_n2_ch", {126'd0, sc_xbar_ch_id_o}, 128'd1);
        chk("lat_n2_rob", {125'd0, sc_xbar_rob_num_o}, 128'd5);
        chk("lat_n2_data", sc_xbar_data_o, d_a5);
        step(1'b0, 2'd0, 3'd0, '0, 3'b000);
        chk("lat_n3_valid", {127'd0, sc_xbar_valid_o}, 128'd0);
        chk("lat_hold_data", sc_xbar_data_o, d_a5);

        // Burst of 3 beats per channel with no credit returns.
        do_reset();
        for (int i = 0; i < 9; i++)
            step(1'b1, 2'(i % 3), 3'(i), rnd128(), 3'b000);
        repeat (4) step(1'b0, 2'd0, 3'd0, '0, 3'b000);
        chk("burst_cnt", grant_order.size(), 6);
        for (int i = 0; i < 6 && i < grant_order.size(); i++)
            chk("burst_order", grant_order[i], i % 3);
        for (int c = 0; c < 3; c++) chk("burst_beats", beats_per_ch[c], 2);
        chk("burst_stall_valid", {127'd0, sc_xbar_valid_o}, 128'd0);

        // One ch1 credit back: exactly one ch1 beat two cycles later.
        step(1'b0, 2'd0, 3'd0, '0, 3'b010);
        chk("pop1_c0_valid", {127'd0, sc_xbar_valid_o}, 128'd0);
        step(1'b0, 2'd0, 3'd0, '0, 3'b000);
        chk("pop1_c1_valid", {127'd0, sc_xbar_valid_o}, 128'd1);
        chk("pop1_c1_ch", {126'd0, sc_xbar_ch_id_o}, 128'd1);
        step(1'b0, 2'd0, 3'd0, '0, 3'b000);
        chk("pop1_c2_valid", {127'd0, sc_xbar_valid_o}, 128'd0);

        // Fill ch0 to depth; check ready per channel and ch_id 3.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 3'(i), rnd128(), 3'b000);
        step(1'b1, 2'd0, 3'd7, rnd128(), 3'b000);
        chk("full_ch0_ready", {127'd0, last_ready}, 128'd0);
        step(1'b0, 2'd2, 3'd0, '0, 3'b000);
        chk("ch2_ready", {127'd0, last_ready}, 128'd1);
        step(1'b1, 2'd3, 3'd1, rnd128(), 3'b000);
        chk("ch3_ready", {127'd0, last_ready}, 128'd0);

        // Credit return on ch0 while full: drains through the model checks.
        step(1'b0, 2'd0, 3'd0, '0, 3'b001);
        step(1'b0, 2'd0, 3'd0, '0, 3'b000);

        // Randomized traffic; credit returns only for beats outstanding.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++)
                rpop[c] = ($urandom_range(0, 2) == 0) && (cr_m[c] < CREDITS);
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 3'($urandom), rnd128(), rpop);
        end

        // Load ch0 and catch a live beat, then reset asynchronously.
        step(1'b1, 2'd0, 3'd1, rnd128(), 3'b111 & {cr_m[2] < CREDITS, cr_m[1] < CREDITS, cr_m[0] < CREDITS});
        guard = 0;
        while (sc_xbar_valid_o !== 1'b1 && guard < 200) begin
            for (int c = 0; c < 3; c++) rpop[c] = (cr_m[c] < CREDITS);
            step(1'b1, 2'd0, 3'($urandom), rnd128(), rpop);
            guard++;
        end
        chk("prereset_valid_seen", {127'd0, sc_xbar_valid_o}, 128'd1);
        #2;
        rst_i = 1'b0;
        rtn_push_valid_i  = 1'b0;
        channel_spw_pop_i = '0;
        #1;
        chk("async_rst_valid", {127'd0, sc_xbar_valid_o}, 128'd0);
        chk("async_rst_data", sc_xbar_data_o, 128'd0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) beats_per_ch[c] = 0;
        grant_order.delete();

        // Fresh credits: two beats per channel issue, a third does not.
        for (int i = 0; i < 9; i++) step(1'b1, 2'(i % 3), 3'(i), rnd128(), 3'b000);
        repeat (4) step(1'b0, 2'd0, 3'd0, '0, 3'b000);
        for (int c = 0; c < 3; c++) chk("post_rst_beats", beats_per_ch[c], 2);

        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < 3; c++)
                rpop[c] = ($urandom_range(0, 1) == 0) && (cr_m[c] < CREDITS);
            step(($urandom_range(0, 1) != 0), 2'($urandom_range(0, 3)),
                 3'($urandom), rnd128(), rpop);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
